// File: rtl/draw_pkg.sv
// Shared definitions for the draw engines: FSM encoding, screen geometry and colour key.
package draw_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int DEF_SCREEN_W     = 160;
  localparam int DEF_SCREEN_H     = 120;
  localparam int DEF_COLOUR_WIDTH = 8;
  localparam logic [7:0] DEF_TRANSPARENT = 8'hE3;

  // Counter width that stays legal for a dimension of 1.
  function automatic int safe_clog2(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// ROM read port and frame-buffer write port of a blitter; master is the blitter side.
interface sprite_blitter_if #(
  parameter int X_WIDTH      = 8,
  parameter int Y_WIDTH      = 7,
  parameter int ADDR_WIDTH   = 11,
  parameter int COLOUR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   rom_addr;
  logic [COLOUR_WIDTH-1:0] rom_q;
  logic [X_WIDTH-1:0]      x_out;
  logic [Y_WIDTH-1:0]      y_out;
  logic [COLOUR_WIDTH-1:0] colour;
  logic                    write_en;

  modport master (output rom_addr, x_out, y_out, colour, write_en, input rom_q);
  modport slave  (input rom_addr, x_out, y_out, colour, write_en, output rom_q);
endinterface

// File: rtl/sprite_blitter_scan_counter.sv
// Raster col/row counter with wrap and a flag on the final position.
module scan_counter
  import draw_pkg::*;
#(
  parameter int SPRITE_W = 40,
  parameter int SPRITE_H = 40,
  localparam int COL_W = safe_clog2(SPRITE_W),
  localparam int ROW_W = safe_clog2(SPRITE_H)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last
);

  logic col_end;
  logic row_end;

  assign col_end = (col == COL_W'(SPRITE_W - 1));
  assign row_end = (row == ROW_W'(SPRITE_H - 1));
  assign last    = col_end & row_end;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col <= '0;
      row <= '0;
    end else if (step) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Copies a sprite from an external ROM to the frame buffer, one pixel per clock,
// with optional colour key, horizontal mirroring and right/bottom clipping.
module sprite_blitter
  import draw_pkg::*;
#(
  parameter int SPRITE_W     = 40,
  parameter int SPRITE_H     = 40,
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H,
  parameter int X_WIDTH      = 8,
  parameter int Y_WIDTH      = 7,
  parameter int ADDR_WIDTH   = 11,
  parameter int COLOUR_WIDTH = DEF_COLOUR_WIDTH,
  parameter int ROM_LATENCY  = 1,
  parameter logic [COLOUR_WIDTH-1:0] TRANSPARENT = COLOUR_WIDTH'(DEF_TRANSPARENT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [X_WIDTH-1:0] x_init,
  input  logic [Y_WIDTH-1:0] y_init,
  input  logic               flip_h,
  input  logic               key_en,
  output logic               busy,
  output logic               done,
  sprite_blitter_if.master   bus
);

  localparam int COL_W = safe_clog2(SPRITE_W);
  localparam int ROW_W = safe_clog2(SPRITE_H);

  logic [1:0]         state;
  logic [X_WIDTH-1:0] x_base;
  logic [Y_WIDTH-1:0] y_base;
  logic               flip_lat;
  logic               key_lat;
  logic [2:0]         drain_cnt;

  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               last;
  logic [COL_W-1:0]   src_col;

  logic [X_WIDTH:0]   scr_x;
  logic [Y_WIDTH:0]   scr_y;
  logic [ROM_LATENCY-1:0] pipe_valid;
  logic [X_WIDTH:0]   pipe_x [ROM_LATENCY];
  logic [Y_WIDTH:0]   pipe_y [ROM_LATENCY];
  logic               clip;
  logic               keyed;

  scan_counter #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_scan (
    .clk   (clk),
    .reset (reset),
    .clear (state == ST_IDLE),
    .step  (state == ST_SCAN),
    .col   (col),
    .row   (row),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      x_base    <= '0;
      y_base    <= '0;
      flip_lat  <= 1'b0;
      key_lat   <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          x_base   <= x_init;
          y_base   <= y_init;
          flip_lat <= flip_h;
          key_lat  <= key_en;
          state    <= ST_SCAN;
        end
        ST_SCAN: if (last) begin
          drain_cnt <= '0;
          state     <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drain_cnt == 3'(ROM_LATENCY - 1)) state <= ST_DONE;
          else drain_cnt <= drain_cnt + 3'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign src_col = flip_lat ? (COL_W'(SPRITE_W - 1) - col) : col;
  assign bus.rom_addr = (state == ST_SCAN)
                      ? ADDR_WIDTH'(row) * ADDR_WIDTH'(SPRITE_W) + ADDR_WIDTH'(src_col)
                      : '0;

  // One extra bit keeps off-screen pixels from wrapping back onto column/row 0.
  assign scr_x = (X_WIDTH+1)'(x_base) + (X_WIDTH+1)'(col);
  assign scr_y = (Y_WIDTH+1)'(y_base) + (Y_WIDTH+1)'(row);

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= (state == ST_SCAN);
      for (int i = 1; i < ROM_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_x[0] <= scr_x;
    pipe_y[0] <= scr_y;
    for (int i = 1; i < ROM_LATENCY; i++) begin
      pipe_x[i] <= pipe_x[i-1];
      pipe_y[i] <= pipe_y[i-1];
    end
  end

  assign clip  = (pipe_x[ROM_LATENCY-1] >= (X_WIDTH+1)'(SCREEN_W))
               | (pipe_y[ROM_LATENCY-1] >= (Y_WIDTH+1)'(SCREEN_H));
  assign keyed = key_lat & (bus.rom_q == TRANSPARENT);

  assign bus.write_en = pipe_valid[ROM_LATENCY-1] & ~clip & ~keyed;
  assign bus.x_out    = pipe_x[ROM_LATENCY-1][X_WIDTH-1:0];
  assign bus.y_out    = pipe_y[ROM_LATENCY-1][Y_WIDTH-1:0];
  assign bus.colour   = bus.rom_q;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: 4x2 sprite with ROM latency 1 and 3.
module tb_sprite_blitter;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] c;
    int         rel;
  } wr_t;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    bit         flip;
    bit         key;
    logic [7:0] rom5;
    int         exp_count;
    int         exp_done;
    logic [7:0] first_x;
    logic [6:0] first_y;
    logic [7:0] first_c;
    logic [7:0] last_x;
    logic [6:0] last_y;
    logic [7:0] last_c;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic flip_h = 1'b0;
  logic key_en = 1'b0;
  logic [7:0] x_init = '0;
  logic [6:0] y_init = '0;
  logic busy_a, done_a, busy_b, done_b;

  logic [7:0] rom_mem [8];
  logic [7:0] rom_pipe_a;
  logic [7:0] rom_pipe_b [3];

  int cyc = 0;
  int e_cnt = 0;
  int done_rel = -1;
  int compared = 0;
  int mismatched = 0;
  wr_t got[$];
  wr_t expq[$];

  sprite_blitter_if #(.X_WIDTH(8), .Y_WIDTH(7), .ADDR_WIDTH(11), .COLOUR_WIDTH(8)) bus_a ();
  sprite_blitter_if #(.X_WIDTH(8), .Y_WIDTH(7), .ADDR_WIDTH(11), .COLOUR_WIDTH(8)) bus_b ();

  sprite_blitter #(.SPRITE_W(4), .SPRITE_H(2), .ROM_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .x_init(x_init), .y_init(y_init),
    .flip_h(flip_h), .key_en(key_en), .busy(busy_a), .done(done_a), .bus(bus_a)
  );

  sprite_blitter #(.SPRITE_W(4), .SPRITE_H(2), .ROM_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .x_init(x_init), .y_init(y_init),
    .flip_h(flip_h), .key_en(key_en), .busy(busy_b), .done(done_b), .bus(bus_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM models with one and three cycles of read latency.
  always @(posedge clk) begin
    rom_pipe_a    <= rom_mem[bus_a.rom_addr[2:0]];
    rom_pipe_b[0] <= rom_mem[bus_b.rom_addr[2:0]];
    rom_pipe_b[1] <= rom_pipe_b[0];
    rom_pipe_b[2] <= rom_pipe_b[1];
  end
  assign bus_a.rom_q = rom_pipe_a;
  assign bus_b.rom_q = rom_pipe_b[2];

  task automatic check_int(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_wr(input string name, input wr_t a, input wr_t e);
    compared++;
    if (a.x != e.x || a.y != e.y || a.c != e.c || a.rel != e.rel) begin
      mismatched++;
      $display("[TB] FAIL %s: got (x=%0d y=%0d c=%h rel=%0d), expected (x=%0d y=%0d c=%h rel=%0d)",
               name, a.x, a.y, a.c, a.rel, e.x, e.y, e.c, e.rel);
    end
  endtask

  task automatic load_rom(input logic [7:0] rom5);
    for (int i = 0; i < 8; i++) rom_mem[i] = 8'(i);
    rom_mem[5] = rom5;
  endtask

  // Reference list of writes for a 4x2 sprite on a 160x120 screen.
  task automatic build_exp(input logic [7:0] x, input logic [6:0] y, input bit flip,
                           input bit key, input int lat);
    wr_t w;
    int col, row, sx, sy, a;
    expq.delete();
    for (int k = 0; k < 8; k++) begin
      col = k % 4;
      row = k / 4;
      sx = int'(x) + col;
      sy = int'(y) + row;
      a = row * 4 + (flip ? 3 - col : col);
      if (sx < 160 && sy < 120 && !(key && rom_mem[a] == 8'hE3)) begin
        w.x = 8'(sx);
        w.y = 7'(sy);
        w.c = rom_mem[a];
        w.rel = 1 + k + lat;
        expq.push_back(w);
      end
    end
  endtask

  task automatic run_draw(input bit use_b, input logic [7:0] x, input logic [6:0] y,
                          input bit flip, input bit key, input bit inject);
    int rel;
    bit seen;
    wr_t w;
    got.delete();
    done_rel = -1;
    seen = 1'b0;
    @(negedge clk);
    x_init = x; y_init = y; flip_h = flip; key_en = key;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    e_cnt = cyc;
    start_a = 1'b0;
    start_b = 1'b0;
    x_init = 8'hFF; y_init = 7'h7F; flip_h = ~flip; key_en = ~key;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      rel = cyc - e_cnt + 1;
      if (inject) start_b = (rel == 3 || rel == 12);
      if (use_b ? bus_b.write_en : bus_a.write_en) begin
        w.x   = use_b ? bus_b.x_out  : bus_a.x_out;
        w.y   = use_b ? bus_b.y_out  : bus_a.y_out;
        w.c   = use_b ? bus_b.colour : bus_a.colour;
        w.rel = rel;
        got.push_back(w);
      end
      if (use_b ? done_b : done_a) begin
        done_rel = rel;
        seen = 1'b1;
      end
    end
    if (inject) begin
      @(negedge clk);
      start_b = 1'b0;
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check_int({tag, " write count"}, got.size(), expq.size());
    n = (got.size() < expq.size()) ? got.size() : expq.size();
    for (int i = 0; i < n; i++) check_wr($sformatf("%s write %0d", tag, i), got[i], expq[i]);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    wr_t e;
    string tag;
    tag = $sformatf("vec%0d", idx);
    load_rom(v.rom5);
    build_exp(v.x, v.y, v.flip, v.key, 1);
    run_draw(1'b0, v.x, v.y, v.flip, v.key, 1'b0);
    check_int({tag, " hand count"}, got.size(), v.exp_count);
    check_int({tag, " done cycle"}, done_rel, v.exp_done);
    compare_writes(tag);
    if (got.size() > 0) begin
      e.x = v.first_x; e.y = v.first_y; e.c = v.first_c; e.rel = 2;
      check_wr({tag, " first"}, got[0], e);
      e.x = v.last_x; e.y = v.last_y; e.c = v.last_c; e.rel = got[got.size()-1].rel;
      check_wr({tag, " last"}, got[got.size()-1], e);
    end
  endtask

  vec_t vecs [6];
  int busy_cnt;
  int we_cnt;

  initial begin
    vecs[0] = '{8'd10,  7'd20,  1'b0, 1'b0, 8'h05, 8, 10, 8'd10,  7'd20,  8'h00, 8'd13,  7'd21,  8'h07};
    vecs[1] = '{8'd10,  7'd20,  1'b1, 1'b0, 8'h05, 8, 10, 8'd10,  7'd20,  8'h03, 8'd13,  7'd21,  8'h04};
    vecs[2] = '{8'd10,  7'd20,  1'b0, 1'b1, 8'hE3, 7, 10, 8'd10,  7'd20,  8'h00, 8'd13,  7'd21,  8'h07};
    vecs[3] = '{8'd10,  7'd20,  1'b0, 1'b0, 8'hE3, 8, 10, 8'd10,  7'd20,  8'h00, 8'd13,  7'd21,  8'h07};
    vecs[4] = '{8'd158, 7'd119, 1'b0, 1'b0, 8'h05, 2, 10, 8'd158, 7'd119, 8'h00, 8'd159, 7'd119, 8'h01};
    vecs[5] = '{8'd157, 7'd118, 1'b1, 1'b0, 8'h05, 6, 10, 8'd157, 7'd118, 8'h03, 8'd159, 7'd119, 8'h05};
    load_rom(8'h05);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("reset busy_a", busy_a, 0);
    check_int("reset done_a", done_a, 0);
    check_int("reset write_en_a", bus_a.write_en, 0);
    check_int("reset rom_addr_a", bus_a.rom_addr, 0);
    check_int("reset busy_b", busy_b, 0);
    check_int("reset write_en_b", bus_b.write_en, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

    // Latency 3, with start pulses during SCAN and during the DONE cycle.
    load_rom(8'h05);
    build_exp(8'd10, 7'd20, 1'b0, 1'b0, 3);
    run_draw(1'b1, 8'd10, 7'd20, 1'b0, 1'b0, 1'b1);
    compare_writes("lat3");
    check_int("lat3 done cycle", done_rel, 12);
    if (got.size() > 0) check_int("lat3 first write cycle", got[0].rel, 4);
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy_b) busy_cnt++;
    end
    check_int("lat3 no retrigger busy cycles", busy_cnt, 0);

    // Abort mid-SCAN, then redraw.
    @(negedge clk);
    x_init = 8'd10; y_init = 7'd20; flip_h = 1'b0; key_en = 1'b0; start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_int("abort write_en", bus_a.write_en, 0);
    check_int("abort busy", busy_a, 0);
    check_int("abort done", done_a, 0);
    check_int("abort rom_addr", bus_a.rom_addr, 0);
    reset = 1'b0;
    we_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus_a.write_en || done_a || busy_a) we_cnt++;
    end
    check_int("abort quiet cycles", we_cnt, 0);
    build_exp(8'd10, 7'd20, 1'b0, 1'b0, 1);
    run_draw(1'b0, 8'd10, 7'd20, 1'b0, 1'b0, 1'b0);
    compare_writes("redraw");
    check_int("redraw done cycle", done_rel, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
